nq_apb_master: RTL and testbench
================================

# nq_apb_master

APB initiator for the NanoQuarter memory stage. It turns the pipeline's single-cycle memory read/write flags into APB SETUP/ACCESS transfers toward the APB data/instruction memory slave. It holds the pipeline with `stall` until the slave completes, then returns read data for the memory-result mux. It sits between the execute/memory pipeline stage and the APB memory model.

## Interface
Parameters:
- ADDR_W, 6, memory address width (matches pipeline memaddr)
- DATA_W, 16, data width (matches register/ALU width)
- TIMEOUT, 15, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_read  in  1  pipeline memory read request, level, held while stall high
- req_write  in  1  pipeline memory write request, level, held while stall high
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- stall  out  1  hold pipeline; combinational
- done  out  1  one-cycle pulse, transfer finished (read or write)
- rd_valid  out  1  done & transfer was a read
- rd_data  out  DATA_W  registered read data
- err  out  1  one-cycle pulse with done when transfer failed
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error; present only with NQ_APB_SLVERR_EN

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE → SETUP when (req_read | req_write) & ~done.
  - On that edge capture address, write data and direction.
  - If both requests are high, the write wins.
- SETUP: psel=1, penable=0. Always → ACCESS on the next edge.
- ACCESS: psel=1, penable=1.
  - pready high → IDLE, done=1 next cycle. On a read, rd_data ← prdata.
  - pready low → stay in ACCESS; wait counter increments.
- Timeout: if TIMEOUT≠0 and the wait counter reaches TIMEOUT while pready is low:
  - abort to IDLE;
  - done=1 and err=1;
  - rd_data ← all ones.
- The wait counter clears on entry to SETUP and in IDLE.
- stall = ~done & ((state==IDLE & (req_read|req_write)) | state!=IDLE).
  - The done cycle drops stall, so the pipeline advances.
  - The held request is not re-accepted in that cycle.
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
- pwdata is 0 on reads and outside transfers. paddr and pwrite are 0 in IDLE.
- No back-to-back transfers: at least one IDLE (done) cycle between transfers.

## Timing
- Reset (async): state IDLE, counter 0, all outputs 0 (stall follows its equation with done=0).
- Reset mid-transfer: psel/penable drop immediately, no done pulse.
- Zero-wait transfer:
  - request seen in cycle 0;
  - SETUP in cycle 1, ACCESS in cycle 2;
  - pready sampled high at the end of cycle 2;
  - done/rd_valid in cycle 3.
  - stall is high in cycles 0–2 and low in cycle 3.
- Each wait state adds one cycle.
- A timeout abort reaches done at cycle 2+TIMEOUT+1.
- rd_data holds its value until the next completed read.

## Configuration
- NQ_APB_SLVERR_EN defined:
  - pslverr port exists and is sampled together with pready in ACCESS;
  - pslverr=1 gives err=1 with done;
  - on a read, rd_data ← prdata regardless.
- NQ_APB_SLVERR_EN undefined: no pslverr port; err is raised only by timeout.

## Structure
- Package nq_apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - default ADDR_W/DATA_W;
  - the abort read-data constant (all ones).
- Sub-module nq_apb_wait_cnt holds the wait counter and timeout compare. Inputs: clk, rst, clr, inc. Output: expired. Parameter: TIMEOUT.

## Test plan
- Zero-wait read: req_read=1, addr 6'h05, prdata 16'h1234, pready=1 → psel rises cycle 1, penable cycle 2, rd_valid with rd_data 16'h1234 in cycle 3, stall low in cycle 3.
- Write with 2 wait states: req_write=1, addr 6'h3F, wdata 16'hBEEF, pready low for 2 ACCESS cycles → pwrite=1, pwdata 16'hBEEF stable throughout, done in cycle 5, rd_valid=0.
- Timeout: TIMEOUT=4, pready stuck low → abort after 4 ACCESS cycles, done=1, err=1, rd_data 16'hFFFF, psel=0.
- Simultaneous req_read & req_write → single write transfer; held request not re-issued in the done cycle.
- Async rst asserted during ACCESS → psel, penable, stall, done all 0 immediately; the next request starts cleanly from IDLE.
- With NQ_APB_SLVERR_EN: read with pslverr=1, pready=1 → done, rd_valid, err all 1 in the same cycle.

Source files
------------

// File: rtl/nq_apb_pkg.sv
// nq_apb_pkg: shared state encoding, default widths and abort read-data constant for the APB master.
package nq_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;
  localparam logic [63:0] ABORT_DATA = '1;
endpackage

// File: rtl/nq_apb_wait_cnt.sv
// nq_apb_wait_cnt: counts ACCESS wait cycles and flags when TIMEOUT is reached (TIMEOUT=0 never expires).
module nq_apb_wait_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  assign expired = (TIMEOUT != 0) && (cnt == W'(TIMEOUT));
endmodule

// File: rtl/nq_apb_master.sv
// nq_apb_master: APB initiator turning pipeline read/write flags into SETUP/ACCESS transfers.
// Define NQ_APB_SLVERR_EN to add the pslverr port and report slave errors on err.
module nq_apb_master
  import nq_apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
`ifdef NQ_APB_SLVERR_EN
  input  logic              pslverr,
`endif
  input  logic              pready
);
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic wr_q, accept, fin, aborted, expired, slv, busy;
`ifdef NQ_APB_SLVERR_EN
  assign slv = pslverr;
`else
  assign slv = 1'b0;
`endif
  assign busy    = state != IDLE;
  assign accept  = state == IDLE && (req_read || req_write) && !done;
  assign aborted = state == ACCESS && !pready && expired;
  assign fin     = state == ACCESS && (pready || expired);
  always_comb
    next = state == IDLE  ? (accept ? SETUP : IDLE) :
           state == SETUP ? ACCESS :
           (fin ? IDLE : ACCESS);
  nq_apb_wait_cnt #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .inc    (state == ACCESS && !pready),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= next;
      done  <= fin;
      err   <= aborted || (fin && pready && slv);
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_write;
      end
      if (aborted) rd_data <= ABORT_DATA[DATA_W-1:0];
      else if (fin && !wr_q) rd_data <= prdata;
    end
  // The request flags are levels held through the done cycle, so done masks re-acceptance.
  assign stall    = !done && (busy || req_read || req_write);
  assign rd_valid = done && !wr_q;
  assign psel     = busy;
  assign penable  = state == ACCESS;
  assign paddr    = busy ? addr_q : '0;
  assign pwrite   = busy && wr_q;
  assign pwdata   = (busy && wr_q) ? wdata_q : '0;
endmodule

// File: tb/tb_nq_apb_master.sv
// tb_nq_apb_master: randomized transfers against a cycle-count reference model of the APB master.
module tb_nq_apb_master;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic req_read = 0, req_write = 0, pready = 0, pslverr = 0;
  logic [5:0] req_addr = 0;
  logic [15:0] req_wdata = 0, prdata = 0;
  logic stall, done, rd_valid, err, pwrite, psel, penable;
  logic [15:0] rd_data, pwdata;
  logic [5:0] paddr;
  logic [15:0] rd_model = 0;
  int vectors = 0, miscompares = 0;

  nq_apb_master #(.ADDR_W(6), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .done(done),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .paddr(paddr),
    .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata),
`ifdef NQ_APB_SLVERR_EN
    .pslverr(pslverr),
`endif
    .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave holds pready low for w ACCESS cycles; beyond TO waits the master gives up.
  task automatic xfer(input bit rd, input bit wr, input logic [5:0] a, input logic [15:0] wd,
                      input logic [15:0] pd, input int w, input bit slv);
    bit abort = w > TO;
    bit is_rd = !wr;
    int last = abort ? 3 + TO : 3 + w;
    bit exp_err;
    @(posedge clk); #1;
    req_read = rd; req_write = wr; req_addr = a; req_wdata = wd;
    pready = 1'($urandom); prdata = 16'($urandom); pslverr = 1'($urandom);
    #1;
    chk("c0_stall", stall, 1); chk("c0_psel", psel, 0); chk("c0_paddr", paddr, 0);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (c >= 2 && c < last) begin
        pready = (c - 2) >= w;
        prdata = pready ? pd : 16'($urandom);
        pslverr = pready ? slv : 1'($urandom);
      end else begin
        pready = 1'($urandom); prdata = 16'($urandom); pslverr = 1'($urandom);
      end
      #1;
      if (c < last) begin
        chk("psel", psel, 1); chk("penable", penable, c >= 2);
        chk("stall", stall, 1); chk("done_early", done, 0);
        chk("paddr", paddr, a); chk("pwrite", pwrite, wr);
        chk("pwdata", pwdata, wr ? wd : 16'h0);
      end
    end
    if (abort) rd_model = 16'hFFFF;
    else if (is_rd) rd_model = pd;
`ifdef NQ_APB_SLVERR_EN
    exp_err = abort || slv;
`else
    exp_err = abort;
`endif
    chk("done", done, 1); chk("err", err, exp_err); chk("rd_valid", rd_valid, is_rd);
    chk("rd_data", rd_data, rd_model); chk("done_stall", stall, 0);
    chk("done_psel", psel, 0); chk("done_pwdata", pwdata, 0); chk("done_paddr", paddr, 0);
    @(posedge clk); #1;
    chk("no_reissue_psel", psel, 0); chk("done_clear", done, 0); chk("err_clear", err, 0);
    req_read = 0; req_write = 0;
    #1 chk("idle_stall", stall, 0); chk("rd_hold", rd_data, rd_model);
  endtask

  initial begin
    #12;
    chk("rst_psel", psel, 0); chk("rst_done", done, 0); chk("rst_stall", stall, 0);
    chk("rst_rd_data", rd_data, 0); chk("rst_paddr", paddr, 0);
    @(negedge clk); rst = 0;
    xfer(1, 0, 6'h05, 16'h0000, 16'h1234, 0, 0);
    xfer(0, 1, 6'h3F, 16'hBEEF, 16'h0000, 2, 0);
    xfer(1, 0, 6'h11, 16'h0000, 16'h5555, 10, 0);
    xfer(1, 1, 6'h2A, 16'hCAFE, 16'h7777, 1, 0);
    xfer(1, 0, 6'h07, 16'h0000, 16'hA5A5, TO, 0);
    xfer(1, 0, 6'h08, 16'h0000, 16'h0F0F, TO + 1, 0);
`ifdef NQ_APB_SLVERR_EN
    xfer(1, 0, 6'h09, 16'h0000, 16'h4321, 0, 1);
`endif
    // Reset during ACCESS, then a clean transfer.
    @(posedge clk); #1; req_read = 1; req_addr = 6'h21; pready = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1; req_read = 0;
    #1;
    chk("mid_rst_psel", psel, 0); chk("mid_rst_penable", penable, 0);
    chk("mid_rst_stall", stall, 0); chk("mid_rst_done", done, 0);
    rd_model = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1 chk("post_rst_done", done, 0);
    xfer(1, 0, 6'h22, 16'h0000, 16'h9876, 1, 0);
    for (int i = 0; i < 40; i++) begin
      bit rd = 1'($urandom), wr = 1'($urandom);
      if (!rd && !wr) rd = 1;
      xfer(rd, wr, 6'($urandom), 16'($urandom), 16'($urandom),
           int'($urandom_range(0, TO + 2)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
